sample_loader: RTL and testbench
================================

Name: sample_loader

Overview:
- Upstream feeder for Data Memory Bank I: accepts a stream of receiver samples (valid/ready) and writes them into the bank I sram through its write_addr/write_data/write_en port.
- Manages two ping-pong frame buffers in that sram. Raises frame_ready to the DSP when a buffer is full and holds it until the DSP acknowledges.
- The DSP reads completed frames through its own read_addr_1/read_data_1 port, which is unaffected by this block.

Parameters:
- ADDR_W, 15, sram address width (matches SRAM_ADDR_LEN).
- DATA_W, 16, sample/word width (matches REG_WORD_LEN).
- FRAME_LEN, 1024, samples per frame buffer; power of two, 2 to 2^(ADDR_W-1).
- BASE_ADDR, 0, sram address of buffer 0. Buffer 1 is at BASE_ADDR+FRAME_LEN. BASE_ADDR+2*FRAME_LEN must be <= 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- enable  in  1  capture enable from control logic.
- in_data  in  DATA_W  sample from receiver front end.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  loader can accept a sample this cycle.
- write_addr  out  ADDR_W  bank I sram write address.
- write_data  out  DATA_W  bank I sram write data.
- write_en  out  1  bank I sram write strobe, one cycle per sample.
- frame_ready  out  1  at least one full buffer is awaiting the DSP.
- frame_base  out  ADDR_W  base address of the oldest full buffer; valid while frame_ready=1.
- frame_ack  in  1  one-cycle pulse from the DSP: oldest full buffer consumed.
- overrun  out  1  sticky flag: in_valid was seen while in_ready=0 and enable=1.

Behaviour:
- Reset (rst=0, async): state=IDLE, write_en=0, write_addr=0, write_data=0, in_ready=0, frame_ready=0, frame_base=BASE_ADDR, overrun=0. Also clears idx=0, wr_buf=0, full[1:0]=0, rd_buf=0.
- Reset asserted mid-frame discards everything, including full buffers.
- All outputs are registered except in_ready, which is combinational from state/full: in_ready = (state==FILL) && !full[wr_buf].
- Accept = in_valid && in_ready. On the accept edge the block registers write_en=1, write_addr=BASE_ADDR+wr_buf*FRAME_LEN+idx, write_data=in_data. The sram write therefore occurs one cycle after accept. write_en=0 in every cycle with no accept.
- idx increments per accept. On the accept where idx==FRAME_LEN-1: idx<=0, full[wr_buf]<=1, wr_buf<=~wr_buf.
- frame_ready = |full. frame_base = BASE_ADDR+rd_buf*FRAME_LEN.
- frame_ack with frame_ready=1: full[rd_buf]<=0, rd_buf<=~rd_buf.
- frame_ack with frame_ready=0: ignored.
- Ack and frame completion in the same cycle: both take effect. If they target the same buffer index, the buffer is not full. The ack clear is applied first, then the completion set, so the completion wins for a different index.
- FSM states:
  - IDLE: enable=0. in_ready=0.
  - FILL: enable=1 and full[wr_buf]=0. Accepting samples.
  - STALL: enable=1 and full[wr_buf]=1; both buffers are awaiting the DSP. in_ready=0.
- FSM transitions:
  - IDLE->FILL when enable=1; idx=0 on entry.
  - FILL->STALL on completing a frame when the other buffer is already full and no ack arrives in that cycle.
  - STALL->FILL on frame_ack.
  - Any state->IDLE when enable=0. The partial frame is discarded (idx<=0). full, rd_buf and wr_buf are kept, so completed frames remain available to the DSP.
- overrun sets when enable=1 && in_valid=1 && in_ready=0, including in STALL. It is cleared only by reset.
- Address arithmetic is in ADDR_W bits; the parameter constraint guarantees no wrap.
- Latency: first sample of a frame to frame_ready = FRAME_LEN accepts + 1 cycle. The last sram write and frame_ready rise on the same edge. The DSP reads with 1-cycle sram latency, so the data is valid when the DSP observes frame_ready.

Decomposition:
- Shared definitions include file (alongside the existing bus-width/opcode definitions) holds:
  - FRAME_LEN default
  - loader FSM state encodings (IDLE=2'd0, FILL=2'd1, STALL=2'd2)
  - BASE_ADDR default
- One natural sub-module: pingpong_ctrl. It owns full[1:0], wr_buf, rd_buf and the ack/complete precedence, and exports full_wr, frame_ready and rd_buf.

Test Plan:
- Reset: rst=0 with in_valid=1, enable=1 -> all outputs at reset values, no write_en; after rst=1, in_ready=1 within 1 cycle.
- Single frame, FRAME_LEN=8: enable=1, stream samples 1..8 continuously.
  - write_en pulses 8 times, at addr 0..7 with data 1..8.
  - frame_ready=1 and frame_base=0 on the edge of the 8th write.
  - Sram locations 0..7 read back 1..8.
- Ping-pong, FRAME_LEN=8: stream 16 samples with no ack -> second frame goes to addr 8..15; frame_base stays 0.
  - Ack -> frame_base=8, frame_ready=1.
  - Ack -> frame_ready=0.
- Stall/overrun: stream 20 samples with no ack -> in_ready=0 after the 16th accept, overrun=1 on the 17th valid, no write_en.
  - Then pulse frame_ack -> in_ready=1 next cycle; the next accept writes addr 0.
- Simultaneous ack and completion: both buffers pending, ack coincides with the 16th accept -> no STALL entry; in_ready stays 1; frame_ready stays 1 with frame_base=8.
- Enable drop mid-frame: after 5 samples of buffer 0, enable=0 for 3 cycles, then re-enable -> the next sample writes addr 0; frame_ready stays 0; overrun stays 0.

Source files
------------

// File: rtl/sample_loader_pkg.sv
// sample_loader_pkg: shared definitions for the bank I sample loader.
//   FRAME_LEN_DEF - default samples per ping-pong frame buffer
//   BASE_ADDR_DEF - default sram address of buffer 0
//   ld_state_e    - loader FSM state encoding
package sample_loader_pkg;

   localparam int FRAME_LEN_DEF = 1024;
   localparam int BASE_ADDR_DEF = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_STALL = 2'd2
   } ld_state_e;

endpackage

// File: rtl/sample_loader_pingpong_ctrl.sv
// sample_loader_pingpong_ctrl: ownership of the two frame buffers.
//   clk, rst     - clock, async active-low reset
//   complete     - write buffer has just received its last sample
//   ack          - DSP consumed the oldest full buffer (ignored if none full)
//   full_wr      - buffer currently being written is still full
//   full_oth     - the other buffer is full
//   frame_ready  - at least one buffer awaits the DSP
//   rd_buf       - index of the oldest full buffer
//   wr_buf       - index of the buffer being written
module sample_loader_pingpong_ctrl (
   input  logic clk,
   input  logic rst,
   input  logic complete,
   input  logic ack,
   output logic full_wr,
   output logic full_oth,
   output logic frame_ready,
   output logic rd_buf,
   output logic wr_buf
);

   logic [1:0] full, full_nxt;
   logic       ack_eff;

   assign ack_eff     = ack && (|full);
   assign frame_ready = |full;
   assign full_wr     = full[wr_buf];
   assign full_oth    = full[~wr_buf];

   // Ack clear first, completion set second; if both hit the same index the
   // buffer ends up not full.
   always_comb begin
      full_nxt = full;
      if (ack_eff)
         full_nxt[rd_buf] = 1'b0;
      if (complete && !(ack_eff && (rd_buf == wr_buf)))
         full_nxt[wr_buf] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full   <= 2'b00;
         rd_buf <= 1'b0;
         wr_buf <= 1'b0;
      end else begin
         full <= full_nxt;
         if (ack_eff)
            rd_buf <= ~rd_buf;
         if (complete)
            wr_buf <= ~wr_buf;
      end
   end

endmodule

// File: rtl/sample_loader.sv
// sample_loader: streams receiver samples into bank I sram as two ping-pong
// frames and hands completed frames to the DSP.
//   clk, rst              - clock, async active-low reset
//   enable                - capture enable
//   in_data/valid/ready   - sample stream (valid/ready handshake)
//   write_addr/data/en    - bank I sram write port (registered)
//   frame_ready/base      - oldest full buffer awaiting the DSP
//   frame_ack             - DSP consumed the oldest full buffer
//   overrun               - sticky: sample offered while not ready (enabled)
module sample_loader
   import sample_loader_pkg::*;
#(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int BASE_ADDR = BASE_ADDR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   output logic              write_en,
   output logic              frame_ready,
   output logic [ADDR_W-1:0] frame_base,
   input  logic              frame_ack,
   output logic              overrun
);

   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] FLEN_A = ADDR_W'(FRAME_LEN);
   localparam logic [IDX_W-1:0]  LAST   = IDX_W'(FRAME_LEN - 1);

   ld_state_e        state;
   logic [IDX_W-1:0] idx;
   logic             accept, complete, ack_eff;
   logic             full_wr, full_oth, rd_buf, wr_buf;

   assign in_ready = (state == ST_FILL) && !full_wr;
   assign accept   = in_valid && in_ready;
   assign complete = accept && (idx == LAST);
   assign ack_eff  = frame_ack && frame_ready;

   sample_loader_pingpong_ctrl u_pp (
      .clk         (clk),
      .rst         (rst),
      .complete    (complete),
      .ack         (frame_ack),
      .full_wr     (full_wr),
      .full_oth    (full_oth),
      .frame_ready (frame_ready),
      .rd_buf      (rd_buf),
      .wr_buf      (wr_buf)
   );

   // rd_buf is a flop, so frame_base only changes on a clock edge.
   assign frame_base = BASE_A + (rd_buf ? FLEN_A : '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         write_en   <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         overrun    <= 1'b0;
      end else begin
         write_en <= accept;
         if (accept) begin
            write_addr <= BASE_A + (wr_buf ? FLEN_A : '0) + ADDR_W'(idx);
            write_data <= in_data;
         end
         if (enable && in_valid && !in_ready)
            overrun <= 1'b1;

         if (!enable) begin
            // Partial frame dropped; completed buffers stay with the DSP.
            state <= ST_IDLE;
            idx   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_FILL;
                  idx   <= '0;
               end
               ST_FILL: begin
                  if (accept) begin
                     idx <= complete ? '0 : idx + 1'b1;
                     // Both buffers pending unless the DSP frees one now.
                     if (complete && full_oth && !ack_eff)
                        state <= ST_STALL;
                  end else if (full_wr && !(ack_eff && (rd_buf == wr_buf))) begin
                     // Re-enabled while both buffers were still pending.
                     state <= ST_STALL;
                  end
               end
               ST_STALL: begin
                  if (ack_eff)
                     state <= ST_FILL;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sample_loader.sv
module tb_sample_loader;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int FL     = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] write_data;
   logic              write_en;
   logic              frame_ready;
   logic [ADDR_W-1:0] frame_base;
   logic              frame_ack;
   logic              overrun;

   int total = 0;
   int bad   = 0;
   int nwr   = 0;
   logic [ADDR_W-1:0] log_addr [64];
   logic [DATA_W-1:0] log_data [64];
   logic [DATA_W-1:0] mem      [64];

   sample_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FL), .BASE_ADDR(0)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
      .frame_ready(frame_ready), .frame_base(frame_base),
      .frame_ack(frame_ack), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // sram model + write log, sampled mid-cycle
   always @(negedge clk) begin
      if (rst && write_en && nwr < 64) begin
         log_addr[nwr] = write_addr;
         log_data[nwr] = write_data;
         mem[write_addr[5:0]] = write_data;
         nwr++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; frame_ack = 1'b0;
      tick(); tick();
      rst = 1'b1;
      nwr = 0;
   endtask

   // Wait (bounded) for in_ready, then present one sample for one edge.
   task automatic accept_one(input logic [DATA_W-1:0] v);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      // reset with traffic present
      rst = 1'b0; enable = 1'b1; in_valid = 1'b1; in_data = 16'h55; frame_ack = 1'b0;
      tick(); tick();
      chk("rst_we",    32'(write_en),    32'd0);
      chk("rst_wa",    32'(write_addr),  32'd0);
      chk("rst_wd",    32'(write_data),  32'd0);
      chk("rst_rdy",   32'(in_ready),    32'd0);
      chk("rst_fr",    32'(frame_ready), 32'd0);
      chk("rst_fb",    32'(frame_base),  32'd0);
      chk("rst_ovr",   32'(overrun),     32'd0);
      rst = 1'b1;
      tick();
      chk("rst_rdy1",  32'(in_ready),    32'd1);
      chk("rst_we1",   32'(write_en),    32'd0);

      // single frame
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < FL; i++) begin
         accept_one(16'(i + 1));
         if (i == FL - 2) chk("t1_fr_early", 32'(frame_ready), 32'd0);
      end
      chk("t1_fr",  32'(frame_ready), 32'd1);
      chk("t1_fb",  32'(frame_base),  32'd0);
      chk("t1_we8", 32'(write_en),    32'd1);
      chk("t1_wa8", 32'(write_addr),  32'd7);
      tick(); tick();
      chk("t1_nwr", 32'(nwr), 32'd8);
      for (int i = 0; i < FL; i++) begin
         chk("t1_addr", 32'(log_addr[i]), 32'(i));
         chk("t1_mem",  32'(mem[i]),      32'(i + 1));
      end

      // ping-pong, no ack
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 2 * FL; i++) accept_one(16'(101 + i));
      chk("t2_fb0", 32'(frame_base),  32'd0);
      chk("t2_fr",  32'(frame_ready), 32'd1);
      tick();
      chk("t2_nwr",  32'(nwr),          32'd16);
      chk("t2_a8",   32'(log_addr[8]),  32'd8);
      chk("t2_a15",  32'(log_addr[15]), 32'd15);
      chk("t2_m12",  32'(mem[12]),      32'd113);
      frame_ack = 1'b1; tick(); frame_ack = 1'b0;
      chk("t2_ack1_fb", 32'(frame_base),  32'd8);
      chk("t2_ack1_fr", 32'(frame_ready), 32'd1);
      frame_ack = 1'b1; tick(); frame_ack = 1'b0;
      chk("t2_ack2_fr", 32'(frame_ready), 32'd0);

      // stall / overrun
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 2 * FL; i++) accept_one(16'(i + 1));
      chk("t3_rdy0", 32'(in_ready), 32'd0);
      chk("t3_ovr0", 32'(overrun),  32'd0);
      in_valid = 1'b1; in_data = 16'd17;
      tick();
      chk("t3_ovr1", 32'(overrun),  32'd1);
      chk("t3_we0",  32'(write_en), 32'd0);
      tick(); tick(); tick();
      in_valid = 1'b0;
      chk("t3_nwr",  32'(nwr), 32'd16);
      frame_ack = 1'b1; tick(); frame_ack = 1'b0;
      chk("t3_rdy1", 32'(in_ready), 32'd1);
      accept_one(16'd17);
      chk("t3_wa",   32'(write_addr), 32'd0);
      chk("t3_wd",   32'(write_data), 32'd17);
      chk("t3_ovr_sticky", 32'(overrun), 32'd1);

      // ack coincides with completion of buffer 1
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 2 * FL - 1; i++) accept_one(16'(i + 1));
      frame_ack = 1'b1;
      accept_one(16'd16);
      frame_ack = 1'b0;
      chk("t4_wa",  32'(write_addr),  32'd15);
      chk("t4_rdy", 32'(in_ready),    32'd1);
      chk("t4_fr",  32'(frame_ready), 32'd1);
      chk("t4_fb",  32'(frame_base),  32'd8);
      tick();
      chk("t4_rdy2", 32'(in_ready),   32'd1);

      // enable drop mid-frame
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 5; i++) accept_one(16'(200 + i));
      enable = 1'b0;
      tick(); tick(); tick();
      enable = 1'b1;
      accept_one(16'd300);
      chk("t5_wa",  32'(write_addr),  32'd0);
      chk("t5_wd",  32'(write_data),  32'd300);
      chk("t5_fr",  32'(frame_ready), 32'd0);
      chk("t5_ovr", 32'(overrun),     32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
